vga_layer_sched: RTL and testbench



---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_sched_regbank.sv | 62 ++++++
 rtl/vga_layer_sched.sv | 80 ++++++++
 tb/tb_vga_layer_sched.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared state encoding, register map and reset values for vga_layer_sched (optional VGA_SCHED_ATTRACT_EN)
package vga_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      APPLY = 2'd2,
      BLANK = 2'd3
   } state_t;
   localparam logic [2:0] ADDR_MASK    = 3'd0;
   localparam logic [2:0] ADDR_BG      = 3'd1;
   localparam logic [2:0] ADDR_BLANK   = 3'd2;
   localparam logic [2:0] ADDR_COMMIT  = 3'd3;
   localparam logic [2:0] ADDR_ATTRACT = 3'd4;
   localparam logic [2:0] LAYER_MASK_RST = 3'b111;
   localparam logic [5:0] BG_RGB_RST     = 6'd0;
endpackage

// File: rtl/vga_sched_regbank.sv
// vga_sched_regbank: shadow/active layer config storage; attract colour cycling under VGA_SCHED_ATTRACT_EN
module vga_sched_regbank
   import vga_pkg::*;
#(
   parameter int BLANK_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [2:0]         wr_addr,
   input  logic [5:0]         wr_data,
   input  logic               copy,
`ifdef VGA_SCHED_ATTRACT_EN
   input  logic               tick,
`endif
   output logic [2:0]         mask,
   output logic [5:0]         bg,
   output logic [BLANK_W-1:0] blank_sh
);
   logic [2:0] mask_sh;
   logic [5:0] bg_sh;
`ifdef VGA_SCHED_ATTRACT_EN
   logic       attract_sh;
   logic       attract;
   // shadow and active attract flag
   always_ff @(posedge clk) begin
      if (reset) begin
         attract_sh <= 1'b0;
         attract    <= 1'b0;
      end else begin
         if (wr_en && wr_addr == ADDR_ATTRACT) attract_sh <= wr_data[0];
         if (copy) attract <= attract_sh;
      end
   end
`endif
   // host writes land in the shadow copy only
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_sh  <= LAYER_MASK_RST;
         bg_sh    <= BG_RGB_RST;
         blank_sh <= '0;
      end else if (wr_en) begin
         if (wr_addr == ADDR_MASK)  mask_sh  <= wr_data[2:0];
         if (wr_addr == ADDR_BG)    bg_sh    <= wr_data;
         if (wr_addr == ADDR_BLANK) blank_sh <= wr_data[BLANK_W-1:0];
      end
   end
   // active copy follows shadow only on the copy strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         mask <= LAYER_MASK_RST;
         bg   <= BG_RGB_RST;
      end else if (copy) begin
         mask <= mask_sh;
         bg   <= bg_sh;
`ifdef VGA_SCHED_ATTRACT_EN
      end else if (tick && attract) begin
         bg   <= bg + 6'd1;
`endif
      end
   end
endmodule

// File: rtl/vga_layer_sched.sv
// vga_layer_sched: frame-synchronous commit of layer enables and background colour (optional VGA_SCHED_ATTRACT_EN)
module vga_layer_sched
   import vga_pkg::*;
#(
   parameter int BLANK_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [2:0] wr_addr,
   input  logic [5:0] wr_data,
   output logic       debug_allow,
   output logic       map_allow,
   output logic       wall_allow,
   output logic [5:0] bg_rgb,
   output logic       force_blank,
   output logic       busy
);
   state_t             state, nxt;
   logic [BLANK_W-1:0] blank_cnt, cnt_nxt, blank_sh;
   logic [2:0]         mask;
   logic               wr_en, commit;
   assign wr_ready = !reset && state != APPLY;
   assign wr_en    = wr_valid && wr_ready;
   assign commit   = wr_en && wr_addr == ADDR_COMMIT;
   assign {debug_allow, map_allow, wall_allow} = mask;
   vga_sched_regbank #(.BLANK_W(BLANK_W)) u_regs (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .copy     (state == APPLY),
`ifdef VGA_SCHED_ATTRACT_EN
      .tick     (state == IDLE && frame_start),
`endif
      .mask     (mask),
      .bg       (bg_rgb),
      .blank_sh (blank_sh)
   );
   // next state and blank counter; a commit in BLANK aborts back to ARMED
   always_comb begin
      nxt     = state;
      cnt_nxt = blank_cnt;
      case (state)
         IDLE:  nxt = commit ? ARMED : IDLE;
         ARMED: nxt = frame_start ? APPLY : ARMED;
         APPLY: begin
            cnt_nxt = blank_sh;
            nxt     = blank_sh != '0 ? BLANK : IDLE;
         end
         BLANK: begin
            if (commit) begin
               cnt_nxt = '0;
               nxt     = ARMED;
            end else if (frame_start) begin
               cnt_nxt = blank_cnt - BLANK_W'(1);
               nxt     = blank_cnt == BLANK_W'(1) ? IDLE : BLANK;
            end
         end
         default: nxt = IDLE;
      endcase
   end
   // state, counter and registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         blank_cnt   <= '0;
         force_blank <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= nxt;
         blank_cnt   <= cnt_nxt;
         force_blank <= nxt == BLANK;
         busy        <= nxt != IDLE;
      end
   end
endmodule

// File: tb/tb_vga_layer_sched.sv
// tb_vga_layer_sched: scoreboard bench for vga_layer_sched, attract case under VGA_SCHED_ATTRACT_EN
module tb_vga_layer_sched;
   logic       clk = 1'b0;
   logic       reset, frame_start, wr_valid, wr_ready;
   logic [2:0] wr_addr;
   logic [5:0] wr_data;
   logic       debug_allow, map_allow, wall_allow, force_blank, busy;
   logic [5:0] bg_rgb;
   typedef struct {
      int          cyc;
      string       name;
      logic [11:0] v;
   } exp_t;
   exp_t q[$];
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   vga_layer_sched #(.BLANK_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .debug_allow (debug_allow),
      .map_allow   (map_allow),
      .wall_allow  (wall_allow),
      .bg_rgb      (bg_rgb),
      .force_blank (force_blank),
      .busy        (busy)
   );
   always #5 clk = ~clk;
   // monitor: after each edge, compare every expectation due at this cycle
   always @(posedge clk) begin
      logic [11:0] act;
      exp_t        e;
      cyc = cyc + 1;
      #1;
      act = {debug_allow, map_allow, wall_allow, bg_rgb, force_blank, busy, wr_ready};
      while (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         total++;
         if (act !== e.v)
            $display("FAIL %s cyc=%0d got mask=%b bg=%h fb=%b busy=%b rdy=%b want mask=%b bg=%h fb=%b busy=%b rdy=%b",
                     e.name, cyc, act[11:9], act[8:3], act[2], act[1], act[0],
                     e.v[11:9], e.v[8:3], e.v[2], e.v[1], e.v[0]);
         else
            passed++;
      end
   end
   // expected outputs after the next clock edge
   task automatic chk(input string n, input logic [2:0] m, input logic [5:0] bg,
                      input logic fb, input logic bz, input logic rdy);
      exp_t e;
      e.cyc  = cyc + 1;
      e.name = n;
      e.v    = {m, bg, fb, bz, rdy};
      q.push_back(e);
   endtask
   task automatic drive(input logic r, input logic fs, input logic v, input logic [2:0] a, input logic [5:0] d);
      reset       = r;
      frame_start = fs;
      wr_valid    = v;
      wr_addr     = a;
      wr_data     = d;
      @(negedge clk);
   endtask
   task automatic idle();                                    drive(0, 0, 0, 3'd0, 6'd0); endtask
   task automatic fs();                                      drive(0, 1, 0, 3'd0, 6'd0); endtask
   task automatic wr(input logic [2:0] a, input logic [5:0] d); drive(0, 0, 1, a, d);     endtask
   initial begin
      chk("rst_rdy_low", 3'b111, 6'h00, 0, 0, 0);      drive(1, 0, 0, 3'd0, 6'd0);
      chk("rst_hold", 3'b111, 6'h00, 0, 0, 0);         drive(1, 1, 1, 3'd3, 6'd0);
      chk("reset_state", 3'b111, 6'h00, 0, 0, 1);      idle();
      total++;
      if (wr_ready !== 1'b1) $display("FAIL direct_rdy got %b", wr_ready);
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL direct_busy got %b", busy);
      else passed++;
      chk("shadow_bg_hidden", 3'b111, 6'h00, 0, 0, 1); wr(3'd1, 6'h2A);
      chk("armed", 3'b111, 6'h00, 0, 1, 1);            wr(3'd3, 6'h00);
      chk("apply_no_change", 3'b111, 6'h00, 0, 1, 0);  fs();
      chk("bg_commit", 3'b111, 6'h2A, 0, 0, 1);        idle();
      chk("fs_idle_ignored", 3'b111, 6'h2A, 0, 0, 1);  fs();
      chk("ignored_addr6", 3'b111, 6'h2A, 0, 0, 1);    wr(3'd6, 6'h3F);
      chk("blank_shadow", 3'b111, 6'h2A, 0, 0, 1);     wr(3'd2, 6'd2);
      chk("blank_armed", 3'b111, 6'h2A, 0, 1, 1);      wr(3'd3, 6'd0);
      chk("commit_in_armed", 3'b111, 6'h2A, 0, 1, 1);  wr(3'd3, 6'd0);
      chk("blank_apply", 3'b111, 6'h2A, 0, 1, 0);      fs();
      chk("blank_rise", 3'b111, 6'h2A, 1, 1, 1);       idle();
      chk("blank_hold", 3'b111, 6'h2A, 1, 1, 1);       idle();
      chk("blank_fs2", 3'b111, 6'h2A, 1, 1, 1);        fs();
      chk("blank_fall", 3'b111, 6'h2A, 0, 0, 1);       fs();
      chk("idle_after_blank", 3'b111, 6'h2A, 0, 0, 1); fs();
      wr(3'd2, 6'd0);
      wr(3'd3, 6'd0);
      chk("wr_with_fs", 3'b111, 6'h2A, 0, 1, 0);       drive(0, 1, 1, 3'd0, 6'b000010);
      chk("mask_map_only", 3'b010, 6'h2A, 0, 0, 1);    idle();
      wr(3'd2, 6'd3);
      wr(3'd3, 6'd0);
      fs();
      chk("abort_pre", 3'b010, 6'h2A, 1, 1, 1);        idle();
      chk("abort_commit", 3'b010, 6'h2A, 0, 1, 1);     wr(3'd3, 6'd0);
      fs();
      chk("reblank", 3'b010, 6'h2A, 1, 1, 1);          idle();
      wr(3'd2, 6'd5);
      wr(3'd0, 6'b000101);
      wr(3'd3, 6'd0);
      fs();
      chk("blank5_mask", 3'b101, 6'h2A, 1, 1, 1);      idle();
      chk("reset_in_blank", 3'b111, 6'h00, 0, 0, 0);   drive(1, 0, 0, 3'd0, 6'd0);
      chk("reset_release", 3'b111, 6'h00, 0, 0, 1);    idle();
      chk("fs_after_reset", 3'b111, 6'h00, 0, 0, 1);   fs();
      chk("no_pending", 3'b111, 6'h00, 0, 0, 1);       idle();
`ifdef VGA_SCHED_ATTRACT_EN
      wr(3'd1, 6'h3F);
      wr(3'd4, 6'd1);
      wr(3'd3, 6'd0);
      fs();
      chk("attract_commit", 3'b111, 6'h3F, 0, 0, 1);   idle();
      chk("attract_wrap", 3'b111, 6'h00, 0, 0, 1);     fs();
      chk("attract_inc", 3'b111, 6'h01, 0, 0, 1);      fs();
`else
      wr(3'd4, 6'd1);
      wr(3'd3, 6'd0);
      fs();
      idle();
      chk("no_attract", 3'b111, 6'h00, 0, 0, 1);       fs();
`endif
      idle();
      idle();
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         total++;
         $display("FAIL %s never checked (due cyc %0d, now %0d)", e.name, e.cyc, cyc);
      end
      if (passed !== total) $display("FAIL summary mismatch");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
